// File: rtl/pipelined_nbit_adder.sv
`default_nettype none
// ============================================================================
// Module      : pipelined_nbit_adder
// Description : Streaming N-bit adder with carry-in and carry-out. The
//               operands are cut into STAGES slices of W = N/STAGES bits.
//               One slice is added per stage, and the carry is registered
//               between stages. Upper operand slices ride along in skew
//               registers. Finished low sum slices ride along in deskew
//               registers, so the full sum leaves the last stage aligned.
//               A valid/ready handshake is used on both sides, and a stall
//               freezes the whole pipe.
//               Optional: define NBIT_ADDER_SAT_EN for unsigned saturation.
//               With saturation, sum becomes all ones when c_out is 1.
//               Overflow is always computed from the wrapped sum.
//               N must be a multiple of STAGES.
// Revision    : 1.0 - initial release
// ============================================================================
module pipelined_nbit_adder #(
    parameter int N      = 8,
    parameter int STAGES = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         c_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] sum,
    output logic         c_out,
    output logic         overflow
);
    localparam int W    = N / STAGES;
    localparam int LAST = STAGES - 1;

    // A presented result that is not being taken freezes every stage.
    logic w_stall;
    assign w_stall  = out_valid && !out_ready;
    assign in_ready = !w_stall;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        // Operand bits that still have to be added, including this slice.
        // The current slice always sits at the bottom of w_a/w_b.
        localparam int REM = N - k * W;

        logic [REM-1:0]       w_a;
        logic [REM-1:0]       w_b;
        logic                 w_cin;
        logic                 w_vin;
        logic [W:0]           w_slice;
        logic [(k+1)*W-1:0]   w_s_next;
        logic [(k+1)*W-1:0]   w_s_load;
        logic                 r_v;
        logic                 r_c;
        logic [(k+1)*W-1:0]   r_s;

        if (k == 0) begin : g_first
            assign w_a      = a;
            assign w_b      = b;
            assign w_cin    = c_in;
            assign w_vin    = in_valid;
            assign w_s_next = w_slice[W-1:0];
        end else begin : g_next
            assign w_a      = g_stage[k-1].g_skew.r_a;
            assign w_b      = g_stage[k-1].g_skew.r_b;
            assign w_cin    = g_stage[k-1].r_c;
            assign w_vin    = g_stage[k-1].r_v;
            assign w_s_next = {w_slice[W-1:0], g_stage[k-1].r_s};
        end

        // W-bit ripple for this slice. The top bit is the carry to the next stage.
        assign w_slice = {1'b0, w_a[W-1:0]} + {1'b0, w_b[W-1:0]} + {{W{1'b0}}, w_cin};

        // Stage register: the valid bit, the outgoing carry and the sum bits finished so far.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_v <= 1'b0;
                r_c <= 1'b0;
                r_s <= '0;
            end else if (!w_stall) begin
                r_v <= w_vin;
                r_c <= w_slice[W];
                r_s <= w_s_load;
            end
        end

        if (k < LAST) begin : g_skew
            logic [REM-W-1:0] r_a;
            logic [REM-W-1:0] r_b;

            assign w_s_load = w_s_next;

            // Skew register: carry the operand slices not yet added to the next stage.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_a <= '0;
                    r_b <= '0;
                end else if (!w_stall) begin
                    r_a <= w_a[REM-1:W];
                    r_b <= w_b[REM-1:W];
                end
            end
        end else begin : g_last
            logic w_ovf;
            logic r_ovf;

            // Signed overflow: the operand signs agree, but the sign of the wrapped sum differs.
            assign w_ovf = (w_a[W-1] == w_b[W-1]) && (w_slice[W-1] != w_a[W-1]);

`ifdef NBIT_ADDER_SAT_EN
            assign w_s_load = w_slice[W] ? '1 : w_s_next;
`else
            assign w_s_load = w_s_next;
`endif

            // Overflow flag, registered alongside the final sum.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_ovf <= 1'b0;
                end else if (!w_stall) begin
                    r_ovf <= w_ovf;
                end
            end
        end
    end

    assign out_valid = g_stage[LAST].r_v;
    assign sum       = g_stage[LAST].r_s;
    assign c_out     = g_stage[LAST].r_c;
    assign overflow  = g_stage[LAST].g_last.r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_pipelined_nbit_adder.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipelined_nbit_adder
// Description : Self-checking bench for pipelined_nbit_adder (N=8, STAGES=2).
//               It runs directed scenarios plus randomized handshake traffic,
//               which is checked against an arithmetic reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipelined_nbit_adder;
    localparam int N      = 8;
    localparam int STAGES = 2;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         c_in;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] sum;
    logic         c_out;
    logic         overflow;

    // Observed output bundle: {out_valid, overflow, c_out, sum}.
    logic [N+2:0] obs;
    assign obs = {out_valid, overflow, c_out, sum};

    int n_checks;
    int n_fail;

    pipelined_nbit_adder #(.N(N), .STAGES(STAGES)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .c_in      (c_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .c_out     (c_out),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    // Reference: {overflow, c_out, sum} from integer arithmetic on the operand values.
    function automatic logic [N+1:0] model(input logic [N-1:0] x, input logic [N-1:0] y, input logic ci);
        longint       total;
        longint       stot;
        longint       lim;
        logic         cy;
        logic         ov;
        logic [N-1:0] s;
        total = longint'(x) + longint'(y) + longint'(ci);
        stot  = longint'($signed(x)) + longint'($signed(y)) + longint'(ci);
        lim   = longint'(1) <<< (N - 1);
        cy    = (total >= (longint'(1) <<< N));
        s     = N'(total);
        ov    = (stot > lim - 1) || (stot < -lim);
`ifdef NBIT_ADDER_SAT_EN
        if (cy) s = '1;
`endif
        return {ov, cy, s};
    endfunction

    // Send one operand set into an idle pipe and count the edges until out_valid appears.
    task automatic issue(input logic [N-1:0] x, input logic [N-1:0] y, input logic ci, output int lat);
        @(negedge clk);
        a = x; b = y; c_in = ci; in_valid = 1'b1; out_ready = 1'b1;
        lat = -1;
        for (int e = 1; e <= 20; e++) begin
            @(negedge clk);
            in_valid = 1'b0;
            if (out_valid === 1'b1) begin
                lat = e;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; c_in = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({obs, in_ready} !== {{(N+3){1'b0}}, 1'b1}) begin
            n_fail++;
            $display("FAIL reset_state: got obs=%h in_ready=%b, want obs=0 in_ready=1", obs, in_ready);
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({obs, in_ready} !== {{(N+3){1'b0}}, 1'b1}) begin
            n_fail++;
            $display("FAIL after_reset_idle: got obs=%h in_ready=%b, want obs=0 in_ready=1", obs, in_ready);
        end
    endtask

    task automatic test_basic();
        int lat;
        issue(N'(12), N'(24), 1'b0, lat);
        n_checks++;
        if (lat !== STAGES) begin
            n_fail++;
            $display("FAIL latency: got %0d edges, want %0d", lat, STAGES);
        end
        n_checks++;
        if (obs !== {3'b100, N'(36)}) begin
            n_fail++;
            $display("FAIL add_12_24: got %h, want %h", obs, {3'b100, N'(36)});
        end
        issue(N'(10), N'(13), 1'b1, lat);
        n_checks++;
        if (obs !== {3'b100, N'(24)}) begin
            n_fail++;
            $display("FAIL add_10_13_ci: got %h, want %h", obs, {3'b100, N'(24)});
        end
    endtask

    task automatic test_carry_wrap();
        int           lat;
        logic [N+2:0] exp;
`ifdef NBIT_ADDER_SAT_EN
        exp = {3'b101, N'(255)};
`else
        exp = {3'b101, N'(44)};
`endif
        issue(N'(200), N'(100), 1'b0, lat);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL carry_200_100: got %h, want %h", obs, exp);
        end
        issue(N'(255), N'(255), 1'b1, lat);
        n_checks++;
        if (obs !== {3'b101, N'(255)}) begin
            n_fail++;
            $display("FAIL max_operands: got %h, want %h", obs, {3'b101, N'(255)});
        end
    endtask

    task automatic test_overflow();
        int lat;
        issue(N'(100), N'(100), 1'b0, lat);
        n_checks++;
        if (obs !== {3'b110, N'(200)}) begin
            n_fail++;
            $display("FAIL ovf_100_100: got %h, want %h", obs, {3'b110, N'(200)});
        end
        issue(N'(25), N'(22), 1'b0, lat);
        n_checks++;
        if (obs !== {3'b100, N'(47)}) begin
            n_fail++;
            $display("FAIL no_ovf_25_22: got %h, want %h", obs, {3'b100, N'(47)});
        end
        issue(N'(127), N'(0), 1'b1, lat);
        n_checks++;
        if (obs !== {3'b110, N'(128)}) begin
            n_fail++;
            $display("FAIL ovf_by_cin: got %h, want %h", obs, {3'b110, N'(128)});
        end
    endtask

    task automatic test_streaming();
        logic [N-1:0] xs [4];
        logic [N+2:0] exp [4];
        logic [N+2:0] got [$];
        int           first;
        int           last;
        xs[0] = N'(1); xs[1] = N'(2); xs[2] = N'(3); xs[3] = N'(255);
        exp[0] = {3'b100, N'(2)};
        exp[1] = {3'b100, N'(4)};
        exp[2] = {3'b100, N'(6)};
`ifdef NBIT_ADDER_SAT_EN
        exp[3] = {3'b101, N'(255)};
`else
        exp[3] = {3'b101, N'(0)};
`endif
        first = -1;
        last  = -1;
        out_ready = 1'b1;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (out_valid === 1'b1) begin
                got.push_back(obs);
                if (first < 0) first = c;
                last = c;
            end
            if (c < 4) begin
                a = xs[c]; b = (c == 3) ? N'(1) : xs[c]; c_in = 1'b0; in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
        end
        n_checks++;
        if (got.size() != 4 || first != STAGES || last - first != 3) begin
            n_fail++;
            $display("FAIL stream_shape: got %0d results at cycles %0d..%0d, want 4 at %0d..%0d",
                     got.size(), first, last, STAGES, STAGES + 3);
        end
        for (int j = 0; j < 4; j++) begin
            if (j < got.size()) begin
                n_checks++;
                if (got[j] !== exp[j]) begin
                    n_fail++;
                    $display("FAIL stream_result%0d: got %h, want %h", j, got[j], exp[j]);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        @(negedge clk); out_ready = 1'b1; in_valid = 1'b1; a = N'(12); b = N'(24); c_in = 1'b0;
        @(negedge clk); a = N'(10); b = N'(13); c_in = 1'b1;
        @(negedge clk); out_ready = 1'b0; a = N'(5); b = N'(6); c_in = 1'b0;
        #1;
        n_checks++;
        if ({obs, in_ready} !== {3'b100, N'(36), 1'b0}) begin
            n_fail++;
            $display("FAIL stall_start: got obs=%h in_ready=%b, want obs=%h in_ready=0", obs, in_ready, {3'b100, N'(36)});
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            n_checks++;
            if ({obs, in_ready} !== {3'b100, N'(36), 1'b0}) begin
                n_fail++;
                $display("FAIL stall_hold%0d: got obs=%h in_ready=%b, want obs=%h in_ready=0", i, obs, in_ready, {3'b100, N'(36)});
            end
        end
        out_ready = 1'b1;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL stall_release_ready: got in_ready=%b, want 1", in_ready);
        end
        @(negedge clk); in_valid = 1'b0;
        n_checks++;
        if (obs !== {3'b100, N'(24)}) begin
            n_fail++;
            $display("FAIL after_stall_1: got %h, want %h", obs, {3'b100, N'(24)});
        end
        @(negedge clk);
        n_checks++;
        if (obs !== {3'b100, N'(11)}) begin
            n_fail++;
            $display("FAIL after_stall_2: got %h, want %h", obs, {3'b100, N'(11)});
        end
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL after_stall_empty: got out_valid=%b, want 0", out_valid);
        end
    endtask

    task automatic test_reset_midflight();
        int lat;
        int stale;
        @(negedge clk); out_ready = 1'b1; in_valid = 1'b1; a = N'(12); b = N'(24); c_in = 1'b0;
        @(negedge clk); a = N'(200); b = N'(100);
        @(negedge clk);
        n_checks++;
        if (obs !== {3'b100, N'(36)}) begin
            n_fail++;
            $display("FAIL pre_reset_result: got %h, want %h", obs, {3'b100, N'(36)});
        end
        in_valid = 1'b0; out_ready = 1'b0;
        #1 rst = 1'b1;
        #1;
        n_checks++;
        if ({obs, in_ready} !== {{(N+3){1'b0}}, 1'b1}) begin
            n_fail++;
            $display("FAIL async_reset_clear: got obs=%h in_ready=%b, want obs=0 in_ready=1", obs, in_ready);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0; out_ready = 1'b1;
        stale = 0;
        repeat (6) begin
            @(negedge clk);
            if (out_valid !== 1'b0) stale++;
        end
        n_checks++;
        if (stale != 0) begin
            n_fail++;
            $display("FAIL stale_after_reset: got %0d valid cycles, want 0", stale);
        end
        issue(N'(25), N'(22), 1'b0, lat);
        n_checks++;
        if (obs !== {3'b100, N'(47)} || lat !== STAGES) begin
            n_fail++;
            $display("FAIL post_reset_add: got %h lat=%0d, want %h lat=%0d", obs, lat, {3'b100, N'(47)}, STAGES);
        end
    endtask

    task automatic test_random();
        logic [N+1:0] q [$];
        logic [N+1:0] e;
        logic [N+2:0] prev_obs;
        logic         prev_stall;
        logic         stall;
        int           drain;
        prev_stall = 1'b0;
        prev_obs   = '0;
        @(negedge clk);
        for (int cyc = 0; cyc < 400; cyc++) begin
            a         = N'($urandom);
            b         = N'($urandom);
            c_in      = 1'($urandom);
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
            stall = out_valid && !out_ready;
            n_checks++;
            if (in_ready !== !stall) begin
                n_fail++;
                $display("FAIL rnd_in_ready cyc%0d: got %b, want %b", cyc, in_ready, !stall);
            end
            if (prev_stall) begin
                n_checks++;
                if (obs !== prev_obs) begin
                    n_fail++;
                    $display("FAIL rnd_hold cyc%0d: got %h, want %h", cyc, obs, prev_obs);
                end
            end
            if (out_valid === 1'b1 && out_ready) begin
                n_checks++;
                if (q.size() == 0) begin
                    n_fail++;
                    $display("FAIL rnd_spurious cyc%0d: got result %h, want none", cyc, obs);
                end else begin
                    e = q.pop_front();
                    if (obs[N+1:0] !== e) begin
                        n_fail++;
                        $display("FAIL rnd_result cyc%0d: got %h, want %h", cyc, obs[N+1:0], e);
                    end
                end
            end
            if (in_valid && !stall) q.push_back(model(a, b, c_in));
            prev_stall = stall;
            prev_obs   = obs;
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        drain     = 0;
        #1;
        while (q.size() != 0 && drain < 4 * STAGES + 8) begin
            if (out_valid === 1'b1) begin
                e = q.pop_front();
                n_checks++;
                if (obs[N+1:0] !== e) begin
                    n_fail++;
                    $display("FAIL rnd_drain: got %h, want %h", obs[N+1:0], e);
                end
            end
            @(negedge clk);
            #1;
            drain++;
        end
        n_checks++;
        if (q.size() != 0 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rnd_drain_end: got %0d missing, out_valid=%b, want 0 missing, out_valid=0", q.size(), out_valid);
        end
    endtask

    initial begin
        clk = 1'b0;
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_basic();
        test_carry_wrap();
        test_overflow();
        test_streaming();
        test_backpressure();
        test_reset_midflight();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Guard against a hung run.
    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
